// File: rtl/test_reg_bank_if.sv
// TileLink-UL request/response bundle types and the host/device
// interface that carries them between the bus and the register bank.
package test_reg_bank_pkg;

    localparam logic [2:0] op_put_full = 3'd0;
    localparam logic [2:0] op_put_part = 3'd1;
    localparam logic [2:0] op_get      = 3'd4;
    localparam logic [2:0] op_ack      = 3'd0;
    localparam logic [2:0] op_ack_data = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
    } tilelink_a;

    typedef struct packed {
        logic        d_valid;
        logic        d_ready;
        logic [2:0]  d_opcode;
        logic [1:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
    } tilelink_d;

endpackage

interface test_reg_bank_if;
    import test_reg_bank_pkg::*;

    tilelink_a tick_tla;
    logic      tick_d_ready;
    logic      bus_a_ready;
    tilelink_d bus_tld;

    modport master (
        output tick_tla,
        output tick_d_ready,
        input  bus_a_ready,
        input  bus_tld
    );

    modport slave (
        input  tick_tla,
        input  tick_d_ready,
        output bus_a_ready,
        output bus_tld
    );

endinterface

// File: rtl/test_reg_bank.sv
// TileLink-UL register bank: reg_count 32-bit registers in one address
// window, with read-only protection and a one-entry response buffer.
module test_reg_bank
    import test_reg_bank_pkg::*;
#(
    parameter logic [31:0] addr_mask = 32'hF0000000,
    parameter logic [31:0] addr_tag  = 32'hF0000000,
    parameter int          reg_count = 4,
    parameter logic [31:0] init      = 32'h0,
    parameter logic [63:0] ro_mask   = 64'h0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    test_reg_bank_if.slave            bus,
    output logic [32*reg_count-1:0]   bus_regs
);

    localparam int idx_w = (reg_count > 1) ? $clog2(reg_count) : 0;
    localparam int iw    = (idx_w > 0) ? idx_w : 1;
    localparam logic [31:0] low_mask = (32'd1 << (2 + idx_w)) - 32'd1;

    typedef enum logic { IDLE, FULL } state_t;

    state_t      state;
    state_t      state_nx;
    tilelink_a   tla;
    logic [iw-1:0] idx;
    logic        cs;
    logic        oor;
    logic        a_ready;
    logic        accept;
    logic        is_get;
    logic        is_put;
    logic        ro;
    logic        write_en;
    logic [31:0] rdata;
    logic [31:0] wmask;
    logic [31:0] regs [reg_count];

    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;

    logic        unused_bits;

    assign tla = bus.tick_tla;
    assign unused_bits = ^tla.a_param;

    generate
        if (idx_w > 0) begin : g_idx
            assign idx = tla.a_address[2 +: iw];
        end else begin : g_no_idx
            assign idx = '0;
        end
    endgenerate

    assign cs = tla.a_valid && ((tla.a_address & addr_mask) == addr_tag);
    // Bits above the index that the window compare does not cover.
    assign oor = |(tla.a_address & ~addr_mask & ~low_mask);

    assign a_ready = (state == IDLE) || bus.tick_d_ready;
    assign accept  = cs && a_ready;
    assign bus.bus_a_ready = a_ready;

    assign is_get = (tla.a_opcode == op_get);
    assign is_put = (tla.a_opcode == op_put_full) ||
                    (tla.a_opcode == op_put_part);

    assign wmask = {{8{tla.a_mask[3]}}, {8{tla.a_mask[2]}},
                    {8{tla.a_mask[1]}}, {8{tla.a_mask[0]}}};

    always_comb begin
        rdata = '0;
        ro    = 1'b0;
        for (int i = 0; i < reg_count; i++) begin
            if (idx == iw'(i)) begin
                rdata = regs[i];
                ro    = ro_mask[i];
            end
        end
    end

    assign write_en = accept && is_put && !oor && !ro;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < reg_count; i++) begin
                regs[i] <= init;
            end
        end else begin
            for (int i = 0; i < reg_count; i++) begin
                if (write_en && idx == iw'(i)) begin
                    regs[i] <= (regs[i] & ~wmask) | (tla.a_data & wmask);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A retiring response may be replaced by a new one in the same cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = FULL;
            FULL: if (bus.tick_d_ready && !accept) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_opcode <= op_ack_data;
            d_size   <= '0;
            d_source <= '0;
            d_data   <= '0;
            d_error  <= 1'b0;
        end else if (accept) begin
            d_opcode <= is_get ? op_ack_data : op_ack;
            d_size   <= tla.a_size;
            d_source <= tla.a_source;
            d_data   <= (is_get && !oor) ? rdata : 32'h0;
            d_error  <= oor || !(is_get || is_put) || (is_put && ro);
        end
    end

    always_comb begin
        bus.bus_tld          = '0;
        bus.bus_tld.d_valid  = (state == FULL);
        bus.bus_tld.d_ready  = 1'b1;
        bus.bus_tld.d_opcode = d_opcode;
        bus.bus_tld.d_param  = 2'b00;
        bus.bus_tld.d_size   = d_size;
        bus.bus_tld.d_source = d_source;
        bus.bus_tld.d_sink   = 1'b0;
        bus.bus_tld.d_data   = d_data;
        bus.bus_tld.d_error  = d_error;
    end

    generate
        for (genvar g = 0; g < reg_count; g++) begin : g_flat
            assign bus_regs[32*g +: 32] = regs[g];
        end
    endgenerate

endmodule

// File: doc/test_reg_bank.md
# test_reg_bank

Parametrised TileLink-UL register bank: `reg_count` 32-bit registers behind one address window. It accepts Get, PutFullData and PutPartialData and returns AccessAckData or AccessAck through a one-entry response buffer that honours host back-pressure. Per-register read-only protection and decode errors are supported. It sits on the pinwheel peripheral bus next to RAMs and debug registers, as the general replacement for single test registers.

## Interface
Parameters:
- `addr_mask`, default 32'hF0000000: address bits compared for window select.
- `addr_tag`, default 32'hF0000000: required value of `a_address & addr_mask`.
- `reg_count`, default 4: number of registers; power of two, 1..64.
- `init`, default 0: reset value of every register.
- `ro_mask`, default 0: bit i set makes register i read-only. Width 64; bits at or above `reg_count` are ignored.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick_tla`  in  tilelink_a  request channel; qualified by `a_valid`.
- `tick_d_ready`  in  1  host can accept the response this cycle.
- `bus_a_ready`  out  1  request accepted this cycle if `a_valid` and selected.
- `bus_tld`  out  tilelink_d  response channel, registered.
- `bus_regs`  out  32*reg_count  flat register contents; register i is at bits [32i+31:32i].

## Operation
- `idx_w` = clog2(`reg_count`), minimum 0. Index is `a_address[2+idx_w-1:2]`. `a_address[1:0]` is ignored.
- Select `cs` = `a_valid` && ((`a_address` & `addr_mask`) == `addr_tag`).
- Out-of-range access: any `a_address` bit set above the index field that is not covered by `addr_mask` is an error access.
- `bus_a_ready` = !`d_valid` || `tick_d_ready`. The value is combinational from registered state and the input, and is independent of `a_valid`.
- Accept = `cs` && `bus_a_ready`. Unselected requests are ignored: no state change and no response.
- On accept, the response loads on the next edge:
  - `d_valid` = 1, `d_source` = `a_source`, `d_size` = `a_size`, `d_param` = 0, `d_sink` = 0.
- Get (TL::Get, 4): `d_opcode` = AccessAckData (1), `d_data` = reg[idx], `d_error` = 0.
- PutFullData (0) / PutPartialData (1):
  - `d_opcode` = AccessAck (0), `d_data` = 0.
  - Unless read-only, reg[idx] = (reg & ~m) | (`a_data` & m), where m is `a_mask` expanded byte-wise to 32 bits.
  - PutFull uses `a_mask` as given; no forcing to 4'hF.
- Error cases:
  - Write to a read-only register: no update, `d_error` = 1.
  - Out-of-range access: no update, `d_error` = 1, `d_data` = 0.
  - Any other opcode: AccessAck, `d_error` = 1, no update.
- Response buffer states:
  - IDLE (`d_valid` = 0): goes to FULL on accept.
  - FULL (`d_valid` = 1), `tick_d_ready` = 1 with accept: stays FULL and is overwritten with the new response (back-to-back).
  - FULL, `tick_d_ready` = 1 without accept: goes to IDLE.
  - FULL, `tick_d_ready` = 0: holds all `bus_tld` fields stable.

## Timing
- Reset (async assert, sync-style deassert on `clock`):
  - Every register = `init`.
  - `d_valid` = 0, `d_opcode` = AccessAckData, `d_data` = 0, `d_error` = 0, `d_source` = 0, `d_size` = 0, `d_param` = 0, `d_sink` = 0.
  - `d_ready` field of `bus_tld` = 1.
  - `bus_a_ready` = 1.
- Latency: request accepted at edge N gives a response valid after edge N. Write data is visible on `bus_regs` after the same edge.
- Get immediately after a Put to the same index returns the new value.
- Throughput: one request per cycle while `tick_d_ready` = 1.
- Reset asserted mid-response drops the pending response with no ack.
- `bus_tld` d_ready field is constant 1.

## Test plan
- Reset with `init` = 32'h1234, `reg_count` = 4 -> `bus_regs` = four copies of 32'h1234; `d_valid` = 0; `bus_a_ready` = 1.
- PutPartial to reg 2 at 0xF0000008, `a_data` = 32'hAABBCCDD, `a_mask` = 4'b0101 -> AccessAck next cycle, `d_error` = 0; reg2 = 32'h00BB00DD over init 0. A following Get returns AccessAckData 32'h00BB00DD with `d_source` echoed.
- With `ro_mask` = 1, PutFull to reg 0 -> `d_error` = 1; reg 0 unchanged. Get of reg 0 -> `d_error` = 0.
- Hold `tick_d_ready` = 0 after a Get -> `bus_a_ready` = 0 and `bus_tld` stable for 5 cycles; the next request waits. Release -> response retires and the next request is accepted that cycle.
- Back-to-back Gets of regs 0..3 with `tick_d_ready` = 1 -> four consecutive valid responses in index order. Address 0x10000000 -> no response; 0xF0000040 with `addr_mask` = F0000000 -> `d_error` = 1.
- Assert `reset_n` = 0 while `d_valid` = 1 -> `d_valid` = 0 immediately; registers = `init`.
